// File: rtl/regfile_pkg.sv
// Shared constants, requester id and holding-buffer entry type for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    typedef struct packed {
        logic              full;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/reg_onehot_decoder.sv
// Address to one-hot register-enable decoder; all outputs low when en is low.
module reg_onehot_decoder #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file's single write port, plus read-address decode.
// Optional same-cycle write-to-read bypass outputs are enabled by REGFILE_WRITE_BYPASS_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned CNT_W    = regfile_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [NUM_REGS-1:0] rd_en1,
    output logic [NUM_REGS-1:0] rd_en2,
    output logic                busy,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                byp_hit1,
    output logic                byp_hit2,
    output logic [DATA_W-1:0]   byp_data
);

    buf_entry_t        buf_a_q, buf_b_q;
    logic              a_older_q;
    logic              tie_q;
    req_e              rr_ptr_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              grant_a, grant_b, grant_any, both_full;
    logic              a_acc, b_acc, stall_cond, wr_issue;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    assign both_full = buf_a_q.full && buf_b_q.full;

    // tie_q marks that the two held entries were accepted in the same cycle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (both_full) begin
            if (tie_q) begin
                grant_a = (rr_ptr_q == REQ_A);
                grant_b = (rr_ptr_q == REQ_B);
            end else begin
                grant_a = a_older_q;
                grant_b = !a_older_q;
            end
        end else begin
            grant_a = buf_a_q.full;
            grant_b = buf_b_q.full;
        end
    end

    assign grant_any = grant_a || grant_b;
    assign gnt_addr  = grant_a ? buf_a_q.addr : buf_b_q.addr;
    assign gnt_data  = grant_a ? buf_a_q.data : buf_b_q.data;
    assign wr_issue  = grant_any && (gnt_addr != '0);

    assign a_ready    = !buf_a_q.full || grant_a;
    assign b_ready    = !buf_b_q.full || grant_b;
    assign a_acc      = a_valid && a_ready;
    assign b_acc      = b_valid && b_ready;
    assign stall_cond = (a_valid && !a_ready) || (b_valid && !b_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a_q     <= '0;
            buf_b_q     <= '0;
            a_older_q   <= 1'b1;
            tie_q       <= 1'b0;
            rr_ptr_q    <= REQ_A;
            stall_cnt_q <= '0;
            wr_data_q   <= '0;
        end else begin
            if (a_acc) begin
                buf_a_q <= '{full: 1'b1, addr: a_addr, data: a_data};
            end else if (grant_a) begin
                buf_a_q.full <= 1'b0;
            end
            if (b_acc) begin
                buf_b_q <= '{full: 1'b1, addr: b_addr, data: b_data};
            end else if (grant_b) begin
                buf_b_q.full <= 1'b0;
            end

            // A lone accept makes the other side (if still held) the older entry.
            if (a_acc && b_acc) begin
                tie_q <= 1'b1;
            end else if (a_acc) begin
                tie_q     <= 1'b0;
                a_older_q <= 1'b0;
            end else if (b_acc) begin
                tie_q     <= 1'b0;
                a_older_q <= 1'b1;
            end

            if (both_full && tie_q) begin
                rr_ptr_q <= (rr_ptr_q == REQ_A) ? REQ_B : REQ_A;
            end

            if (grant_any) begin
                wr_data_q <= gnt_data;
            end

            if (stall_cond && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign wr_data   = grant_any ? gnt_data : wr_data_q;
    assign busy      = buf_a_q.full || buf_b_q.full;
    assign stall_cnt = stall_cnt_q;

    reg_onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_dec (
        .en     (wr_issue),
        .addr   (gnt_addr),
        .onehot (wr_en)
    );

    reg_onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd1_dec (
        .en     (1'b1),
        .addr   (rd_addr1),
        .onehot (rd_en1)
    );

    reg_onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd2_dec (
        .en     (1'b1),
        .addr   (rd_addr2),
        .onehot (rd_en2)
    );

`ifdef REGFILE_WRITE_BYPASS_EN
    assign byp_hit1 = wr_issue && (gnt_addr == rd_addr1);
    assign byp_hit2 = wr_issue && (gnt_addr == rd_addr2);
    assign byp_data = wr_data;
`else
    assign byp_hit1 = 1'b0;
    assign byp_hit2 = 1'b0;
    assign byp_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: timestamp-based reference model predicts writes; a monitor checks them.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [3:0]  a_addr = '0, b_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic [15:0] wr_en, wr_data, rd_en1, rd_en2, byp_data;
    logic        busy, byp_hit1, byp_hit2;
    logic [7:0]  stall_cnt;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_en1    (rd_en1),
        .rd_en2    (rd_en2),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: each requester holds at most one write stamped with its accept cycle.
    bit          ma_full, mb_full;
    logic [3:0]  ma_addr, mb_addr;
    logic [15:0] ma_data, mb_data;
    int          ma_t, mb_t;
    bit          m_rr;
    int          m_stall;
    logic [15:0] m_last;
    int          cyc_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [15:0] onehot(input logic [3:0] a);
        logic [15:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        ma_full = 0; mb_full = 0;
        ma_addr = '0; mb_addr = '0; ma_data = '0; mb_data = '0;
        ma_t = 0; mb_t = 0;
        m_rr = 0; m_stall = 0; m_last = '0;
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next one.
    task automatic cyc(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                       input bit bv, input logic [3:0] ba, input logic [15:0] bd,
                       input logic [3:0] r1, input logic [3:0] r2);
        bit          ga, gb, ra, rb, wr;
        logic [3:0]  gaddr;
        logic [15:0] gdata, exp_wd;
        exp_t        e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rd_addr1 = r1; rd_addr2 = r2;

        ga = 0; gb = 0;
        if (ma_full && mb_full) begin
            if (ma_t < mb_t) ga = 1;
            else if (mb_t < ma_t) gb = 1;
            else begin
                if (!m_rr) ga = 1; else gb = 1;
                m_rr = !m_rr;
            end
        end else begin
            ga = ma_full;
            gb = mb_full;
        end
        gaddr  = ga ? ma_addr : mb_addr;
        gdata  = ga ? ma_data : mb_data;
        wr     = (ga || gb) && (gaddr != 0);
        exp_wd = (ga || gb) ? gdata : m_last;
        ra     = !ma_full || ga;
        rb     = !mb_full || gb;
        if (wr) begin
            e.addr = gaddr;
            e.data = gdata;
            sb_q.push_back(e);
        end

        @(negedge clk);
        check("a_ready", 32'(a_ready), 32'(ra));
        check("b_ready", 32'(b_ready), 32'(rb));
        check("busy", 32'(busy), 32'(ma_full || mb_full));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("rd_en1", 32'(rd_en1), 32'(onehot(r1)));
        check("rd_en2", 32'(rd_en2), 32'(onehot(r2)));
        check("wr_data", 32'(wr_data), 32'(exp_wd));
        if (!wr) check("wr_en_idle", 32'(wr_en), 32'd0);
`ifdef REGFILE_WRITE_BYPASS_EN
        check("byp_hit1", 32'(byp_hit1), 32'(wr && gaddr == r1));
        check("byp_hit2", 32'(byp_hit2), 32'(wr && gaddr == r2));
        check("byp_data", 32'(byp_data), 32'(exp_wd));
`else
        check("byp_hit1", 32'(byp_hit1), 32'd0);
        check("byp_hit2", 32'(byp_hit2), 32'd0);
        check("byp_data", 32'(byp_data), 32'd0);
`endif

        @(posedge clk);
        if (ga) ma_full = 0;
        if (gb) mb_full = 0;
        if (ga || gb) m_last = gdata;
        if (av && ra) begin ma_full = 1; ma_addr = aa; ma_data = ad; ma_t = cyc_n; end
        if (bv && rb) begin mb_full = 1; mb_addr = ba; mb_data = bd; mb_t = cyc_n; end
        if (((av && !ra) || (bv && !rb)) && m_stall < 255) m_stall++;
        cyc_n++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd1, 4'd2);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        model_clear();
        sb_q.delete();
        a_valid = 0;
        b_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en !== 16'h0) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got wr_en %h wr_data %h expected no write",
                         wr_en, wr_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_wr_en", 32'(wr_en), 32'(onehot(e.addr)));
                check("sb_wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        model_clear();
        #12;
        apply_reset();

        // Single write to r3.
        cyc(1, 4'd3, 16'hBEEF, 0, 4'd0, 16'h0, 4'd3, 4'd0);
        idle(2);

        // Same-cycle collision on r5 with B held through the stall.
        cyc(1, 4'd5, 16'h1111, 1, 4'd5, 16'h2222, 4'd5, 4'd0);
        cyc(0, 4'd0, 16'h0, 1, 4'd6, 16'h3333, 4'd5, 4'd6);
        idle(3);

        // Age ordering: tie, then the granted side refills and must wait behind the other.
        cyc(1, 4'd1, 16'hA001, 1, 4'd2, 16'hB002, 4'd1, 4'd2);
        cyc(1, 4'd4, 16'hA004, 1, 4'd8, 16'hB008, 4'd4, 4'd8);
        cyc(1, 4'd9, 16'hA009, 1, 4'd10, 16'hB00A, 4'd9, 4'd10);
        idle(4);

        // R0 write consumes a slot but never raises wr_en.
        cyc(0, 4'd0, 16'h0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
        idle(2);

        // Bypass probe on r7.
        cyc(1, 4'd7, 16'h7777, 0, 4'd0, 16'h0, 4'd7, 4'd2);
        cyc(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd7, 4'd2);
        idle(1);

        // Reset with both buffers full.
        cyc(1, 4'd9, 16'h9999, 1, 4'd10, 16'hAAAA, 4'd9, 4'd10);
        apply_reset();
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 16'($urandom),
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        idle(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - A: pipeline writeback.
  - B: multi-cycle/load unit.
- Each requester has a valid/ready handshake into a 1-entry holding buffer. Buffered writes issue oldest-first, round-robin on ties.
- Drives the one-hot per-register WriteReg enables and the shared D bus.
- Also decodes the two read addresses into one-hot ReadEnable1/ReadEnable2 lines for the tri-state bitlines.

Parameters:
- NUM_REGS, 16, number of registers; one-hot enable width.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.
- DATA_W, 16, register data width.
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's buffer can accept this cycle.
- a_addr  in  ADDR_W  A's destination register.
- a_data  in  DATA_W  A's write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's buffer can accept this cycle.
- b_addr  in  ADDR_W  B's destination register.
- b_data  in  DATA_W  B's write data.
- wr_en  out  NUM_REGS  one-hot WriteReg to each register.
- wr_data  out  DATA_W  shared D bus to all registers.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_en1  out  NUM_REGS  one-hot ReadEnable1.
- rd_en2  out  NUM_REGS  one-hot ReadEnable2.
- busy  out  1  either buffer holds a pending write.
- stall_cnt  out  CNT_W  cycles with a valid requester held off; saturating.
- byp_hit1  out  1  read-port-1 bypass hit (optional feature).
- byp_hit2  out  1  read-port-2 bypass hit (optional feature).
- byp_data  out  DATA_W  bypassed write data (optional feature).

Behaviour:
- Reset (async, immediate), including mid-operation:
  - Both buffers empty; pending writes are discarded.
  - Age bit a_older = 1, rr_ptr = A, stall_cnt = 0.
  - wr_en = 0, wr_data = 0, busy = 0.
  - a_ready = b_ready = 1 after reset deasserts.
- Accept and ready:
  - Accept X when X_valid && X_ready.
  - On accept, addr/data load into buf_X at the rising edge.
  - X_ready = !buf_X_full || grant_X. Draining and refilling in the same cycle is legal, giving 1 write/cycle/requester throughput.
- Grant (combinational from buffer state):
  - Only one buffer full: grant it.
  - Both full, different accept cycles: grant the older; a_older tracks which was accepted first.
  - Both full, accepted the same cycle: grant rr_ptr, then toggle rr_ptr.
  - Same-address pairs therefore always write in acceptance order. On a same-cycle tie the later grant wins the final value.
- Write issue:
  - wr_en = onehot(buf_granted.addr); wr_data = buf_granted.data. Active for exactly one cycle; the register captures it at the end of that cycle.
  - Latency: accept edge → wr_en high the next cycle. Minimum 1 cycle, maximum 2 cycles under contention.
  - When no grant: wr_en = 0, wr_data holds its last value.
- R0 is hardwired zero: a write to addr 0 is accepted and granted (consumes its slot), but wr_en stays 0.
- Read enables: rd_en1 = onehot(rd_addr1) and rd_en2 = onehot(rd_addr2), purely combinational, never more than one bit set.
- Stall counter: stall_cnt increments when (a_valid && !a_ready) || (b_valid && !b_ready); it saturates at 2**CNT_W-1.
- busy = buf_A_full || buf_B_full.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - byp_hit1 = wr_en granted, granted addr != 0, and addr == rd_addr1.
  - byp_hit2 is the same comparison against rd_addr2.
  - byp_data = wr_data.
  - The decode stage muxes byp_data over the bitline value on a hit (write-before-read in the same cycle).
- Undefined: byp_hit1 = byp_hit2 = 0 and byp_data = 0; the ports remain present.

Decomposition:
- Package regfile_pkg holds ADDR_W, DATA_W, NUM_REGS constants, the requester-id enum (REQ_A, REQ_B), and the buffer-entry struct (full, addr, data).
- Sub-module reg_onehot_decoder (ADDR_W → NUM_REGS, with an enable input) is instantiated three times: write, read 1, read 2.

Test Plan:
- Reset, then single write: a_valid with a_addr=3, a_data=16'hBEEF → wr_en=16'h0008 and wr_data=16'hBEEF exactly one cycle later for one cycle; busy=1 for that cycle.
- Same-cycle collision: A(addr 5, 16'h1111) and B(addr 5, 16'h2222) accepted together → A written at cycle +1 (wr_en=16'h0020), B at cycle +2; b_ready=0 for one cycle; stall_cnt=1 if b_valid is held.
- Age ordering: B accepted at cycle t while A is stalled; A accepted at t+1 → B granted before A regardless of rr_ptr.
- R0 write: b_addr=0, b_data=16'hFFFF → wr_en=0 every cycle; the buffer drains and b_ready returns to 1 the next cycle.
- Reset mid-operation: both buffers full, assert rst → wr_en=0 and busy=0 immediately; no write issues after release.
- Bypass (macro defined): grant to addr 7 with rd_addr1=7 and rd_addr2=2 → byp_hit1=1, byp_hit2=0, byp_data=wr_data, rd_en1=16'h0080. Macro undefined → both hits 0.
